// File: rtl/button_pkg.sv
// Shared types and constants for the push-button reader.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        HELD
    } btn_state_t;

    localparam int PRESS_COUNT_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous board pins.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_sense.sv
// Debounced push-button reader with press/release/long-press strobes and a press count.
// Long-press detection is built only when BUTTON_LONG_PRESS_EN is defined.
module button_sense
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 12000,
    parameter int LONG_PRESS_CYCLES = 6000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     btn_n,
    output logic                     btn_level,
    output logic                     press_pulse,
    output logic                     release_pulse,
    output logic                     long_pulse,
    output logic [PRESS_COUNT_W-1:0] press_count
);

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_sync_n;
    logic             btn_sync;
    logic [DEB_W-1:0] deb_cnt;
    logic             accept;
    logic             level_rise;
    logic             level_fall;
    btn_state_t       state;

    // Synchronizer idles at 1 so reset looks like a released button.
    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (btn_n),
        .q  (btn_sync_n)
    );

    assign btn_sync   = ~btn_sync_n;
    assign accept     = (btn_sync != btn_level) && (deb_cnt == DEB_LAST);
    assign level_rise = accept && !btn_level;
    assign level_fall = accept && btn_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_cnt   <= '0;
            btn_level <= 1'b0;
        end else if (btn_sync == btn_level) begin
            deb_cnt <= '0;
        end else if (accept) begin
            deb_cnt   <= '0;
            btn_level <= ~btn_level;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

`ifdef BUTTON_LONG_PRESS_EN

    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    logic [HOLD_W-1:0] hold_cnt;

    // Release is checked before the hold limit so a coincident release wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            press_count   <= '0;
            hold_cnt      <= '0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            hold_cnt      <= '0;
            case (state)
                IDLE: begin
                    if (level_rise) begin
                        state       <= PRESSED;
                        press_pulse <= 1'b1;
                        press_count <= press_count + 1'b1;
                    end
                end
                PRESSED: begin
                    if (level_fall) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state      <= HELD;
                        long_pulse <= 1'b1;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt;
                    end
                end
                HELD: begin
                    if (level_fall) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`else

    assign long_pulse = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            press_count   <= '0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (level_rise) begin
                        state       <= PRESSED;
                        press_pulse <= 1'b1;
                        press_count <= press_count + 1'b1;
                    end
                end
                PRESSED: begin
                    if (level_fall) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_button_sense.sv
// Directed self-checking bench for button_sense (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10).
module tb_button_sense;

    localparam int DEB  = 4;
    localparam int LONG = 10;
`ifdef BUTTON_LONG_PRESS_EN
    localparam logic [31:0] LONG_EN = 32'd1;
`else
    localparam logic [31:0] LONG_EN = 32'd0;
`endif

    logic       clk;
    logic       rst;
    logic       btn_n;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic [7:0] press_count;

    int total;
    int bad;
    int press_seen   = 0;
    int release_seen = 0;
    int long_seen    = 0;
    int p0;
    int r0;
    int l0;

    button_sense #(
        .DEBOUNCE_CYCLES  (DEB),
        .LONG_PRESS_CYCLES(LONG)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_n        (btn_n),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .press_count  (press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (press_pulse)   press_seen   <= press_seen + 1;
        if (release_pulse) release_seen <= release_seen + 1;
        if (long_pulse)    long_seen    <= long_seen + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic level, input int cycles);
        btn_n = level;
        step(cycles);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        btn_n = 1'b1;
        step(3);
        checkOutput("rst_level", btn_level, 0);
        checkOutput("rst_press", press_pulse, 0);
        checkOutput("rst_count", press_count, 0);
        rst = 1'b0;
        step(4);
        checkOutput("idle_level", btn_level, 0);
        checkOutput("idle_release", release_pulse, 0);

        // Clean press held long enough for a long-press, then released.
        $display("[TB] clean and long press");
        l0 = long_seen;
        r0 = release_seen;
        applyStimulus(1'b0, 5);
        checkOutput("pre_press", press_pulse, 0);
        checkOutput("pre_level", btn_level, 0);
        step(1);
        checkOutput("press_edge", press_pulse, 1);
        checkOutput("press_level", btn_level, 1);
        checkOutput("press_count1", press_count, 1);
        step(1);
        checkOutput("press_width", press_pulse, 0);
        step(8);
        checkOutput("long_early", long_pulse, 0);
        step(1);
        checkOutput("long_edge", long_pulse, LONG_EN);
        step(1);
        checkOutput("long_width", long_pulse, 0);
        step(18);
        applyStimulus(1'b1, 5);
        checkOutput("pre_release", release_pulse, 0);
        checkOutput("pre_release_level", btn_level, 1);
        step(1);
        checkOutput("release_edge", release_pulse, 1);
        checkOutput("release_level", btn_level, 0);
        checkOutput("release_long", long_pulse, 0);
        step(1);
        checkOutput("release_width", release_pulse, 0);
        checkOutput("long_once", long_seen - l0, LONG_EN);
        checkOutput("release_once", release_seen - r0, 1);

        // Bounce: 2-cycle toggles never satisfy the 4-cycle filter.
        $display("[TB] bounce");
        step(3);
        p0 = press_seen;
        for (int i = 0; i < 10; i++) applyStimulus((i % 2 == 0) ? 1'b0 : 1'b1, 2);
        checkOutput("bounce_quiet", press_seen - p0, 0);
        checkOutput("bounce_level", btn_level, 0);
        applyStimulus(1'b0, 5);
        checkOutput("bounce_pre", press_pulse, 0);
        step(1);
        checkOutput("bounce_press", press_pulse, 1);
        checkOutput("bounce_count", press_count, 2);
        step(1);
        checkOutput("bounce_single", press_seen - p0, 1);
        applyStimulus(1'b1, 8);
        checkOutput("bounce_released", btn_level, 0);

        // Release accepted exactly when the hold count hits its limit.
        $display("[TB] release/long collision");
        applyStimulus(1'b0, 6);
        checkOutput("col_press", press_pulse, 1);
        checkOutput("col_count", press_count, 3);
        l0 = long_seen;
        r0 = release_seen;
        step(4);
        applyStimulus(1'b1, 5);
        checkOutput("col_pre_long", long_pulse, 0);
        checkOutput("col_pre_release", release_pulse, 0);
        step(1);
        checkOutput("col_release", release_pulse, 1);
        checkOutput("col_long", long_pulse, 0);
        step(3);
        checkOutput("col_no_long", long_seen - l0, 0);
        checkOutput("col_one_release", release_seen - r0, 1);

        // Reset mid-press discards the press; held button re-debounces afterwards.
        $display("[TB] reset mid-press");
        applyStimulus(1'b0, 6);
        checkOutput("rmp_press", press_pulse, 1);
        checkOutput("rmp_count", press_count, 4);
        step(3);
        r0 = release_seen;
        rst = 1'b1;
        #1;
        checkOutput("rmp_level", btn_level, 0);
        checkOutput("rmp_count0", press_count, 0);
        step(2);
        checkOutput("rmp_release", release_pulse, 0);
        rst = 1'b0;
        step(5);
        checkOutput("rmp_pre_press", press_pulse, 0);
        checkOutput("rmp_pre_level", btn_level, 0);
        step(1);
        checkOutput("rmp_fresh_press", press_pulse, 1);
        checkOutput("rmp_fresh_count", press_count, 1);
        step(1);
        checkOutput("rmp_no_release", release_seen - r0, 0);
        applyStimulus(1'b1, 8);

        // Press count wraps from 255 back to 0.
        $display("[TB] count wrap");
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(2);
        for (int i = 0; i < 255; i++) begin
            applyStimulus(1'b0, 7);
            applyStimulus(1'b1, 7);
        end
        checkOutput("wrap_255", press_count, 255);
        applyStimulus(1'b0, 6);
        checkOutput("wrap_press", press_pulse, 1);
        checkOutput("wrap_zero", press_count, 0);
        applyStimulus(1'b1, 8);
        checkOutput("final_level", btn_level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_sense.md
# button_sense

Debounced push-button reader for the UPDuino board: the input-side counterpart to the counter-driven LED outputs. It synchronizes one raw, active-low button pin into the `clk` domain and filters contact bounce with a stability counter. It then tracks press state in a small FSM and emits single-cycle press, release and long-press events plus a wrapping press count. Downstream logic, such as LED mode selection or blink-rate stepping, consumes the events.

## Interface
- `DEBOUNCE_CYCLES`, default 12000: consecutive stable cycles required to accept a level change (1 ms at 12 MHz); legal range ≥ 2.
- `LONG_PRESS_CYCLES`, default 6000000: cycles the debounced press must persist before `long_pulse` fires (0.5 s at 12 MHz); legal range ≥ 1.
- `clk` input 1: system clock; all logic is on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `btn_n` input 1: raw button pin, active-low and asynchronous to `clk`.
- `btn_level` output 1: debounced level, 1 = pressed.
- `press_pulse` output 1: one-cycle strobe on each accepted press.
- `release_pulse` output 1: one-cycle strobe on each accepted release.
- `long_pulse` output 1: one-cycle strobe when a press reaches `LONG_PRESS_CYCLES`.
- `press_count` output 8: number of accepted presses, modulo 256.

## Operation
- **Synchronizer**
  - Two flops on `btn_n`, then inverted to give `btn_sync` (1 = pressed).
  - Both flops reset to 1, meaning released.
- **Debounce counter**
  - Width is `$clog2(DEBOUNCE_CYCLES)`.
  - Clears whenever `btn_sync == btn_level`.
  - Increments each cycle `btn_sync != btn_level`.
  - When it equals `DEBOUNCE_CYCLES-1` and the mismatch persists, `btn_level` toggles at the next edge and the counter clears.
  - Any single-cycle return to `btn_level` restarts the count from 0.
- **FSM**
  - States are `IDLE`, `PRESSED` and `HELD`; reset state is `IDLE`.
  - `IDLE` → `PRESSED` when `btn_level` rises: `press_pulse`=1 and `press_count`+1, both registered in the same edge as the `btn_level` rise.
  - `PRESSED` → `IDLE` when `btn_level` falls: `release_pulse`=1.
  - `PRESSED` → `HELD` when the hold counter reaches `LONG_PRESS_CYCLES-1`: `long_pulse`=1 for one cycle.
  - `HELD` → `IDLE` when `btn_level` falls: `release_pulse`=1.
  - `long_pulse` fires at most once per press.
- **Hold counter**
  - Width is `$clog2(LONG_PRESS_CYCLES+1)`.
  - Counts only in `PRESSED` and clears in every other state.
  - Saturates and never wraps.
- **Press count**
  - Wraps from 255 to 0 with no flag.
- **Simultaneous events**
  - If release is accepted in the same cycle the hold counter reaches its terminal value, release wins: `release_pulse`=1, `long_pulse`=0, next state `IDLE`.
- **Reset**
  - All outputs are 0 during and after reset.
  - Asserting `rst` mid-press discards the press: no `release_pulse` follows.
  - A button still held when reset releases is re-debounced and produces a fresh `press_pulse`.

## Timing
- Latency: a raw edge stable from rising edge k appears on `btn_level` and the matching pulse at edge k+2+`DEBOUNCE_CYCLES`.
- Pulses are registered, exactly one cycle wide, and mutually exclusive.
- `long_pulse` arrives `LONG_PRESS_CYCLES` cycles after `press_pulse`.
- Minimum accepted press width is `DEBOUNCE_CYCLES` stable cycles; shorter glitches produce no output activity.
- No handshake: consumers must sample the strobes every cycle.

## Configuration
- **`BUTTON_LONG_PRESS_EN` defined:** the hold counter, the `HELD` state and `long_pulse` behave as described above.
- **`BUTTON_LONG_PRESS_EN` undefined:**
  - The hold counter and `HELD` are not built.
  - `long_pulse` is tied to 0.
  - The FSM has only `IDLE` and `PRESSED`.
  - All other behaviour and latency are identical.

## Structure
- Shared package `button_pkg`:
  - FSM state enum `btn_state_t` (`IDLE`, `PRESSED`, `HELD`).
  - Constant `PRESS_COUNT_W` = 8.
- Sub-module `sync_2ff`: generic two-flop synchronizer with a reset-value parameter, reusable for other board pins.
- Debounce, FSM and counters live in `button_sense`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `LONG_PRESS_CYCLES`=10.
- **Clean press:** drive `btn_n` low at edge 10 and hold → `press_pulse` high for one cycle at edge 16, `btn_level`=1, `press_count`=1.
- **Bounce:** toggle `btn_n` every 2 cycles for 20 cycles, then hold low → no pulse during toggling; exactly one `press_pulse` 6 cycles after the final low edge.
- **Long press:** hold low 30 cycles → `press_pulse` at t, `long_pulse` at t+10, one `release_pulse` after release, no second `long_pulse`.
- **Release/long collision:** time the release so the accepted release lands on hold count 9 → `release_pulse`=1, `long_pulse`=0, state `IDLE`.
- **Count wrap:** 256 clean presses → `press_count` reads 0 after the 256th.
- **Reset mid-press:** pulse `rst` while `PRESSED` with the button held → outputs 0 and no `release_pulse`; after reset a fresh `press_pulse` arrives 6 cycles later.
